// File: rtl/wrapper_ahb_vr_pkg.sv
// wrapper_ahb_vr_pkg: shared types, AHB encodings and size/strobe helpers
// for the multichannel AHB to valid/ready bridge.
package wrapper_ahb_vr_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [3:0] byte_strobe(input logic [2:0] hsize, input logic [1:0] addr);
        return hsize == HSIZE_BYTE ? 4'b0001 << addr :
               hsize == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
               hsize == HSIZE_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic size_legal(input logic [2:0] hsize, input logic [1:0] addr);
        return hsize == HSIZE_BYTE ||
               (hsize == HSIZE_HALF && !addr[0]) ||
               (hsize == HSIZE_WORD && addr == 2'b00);
    endfunction

endpackage

// File: rtl/wrapper_vr_timeout_counter.sv
// wrapper_vr_timeout_counter: counts stalled data-phase cycles and flags the
// last permitted wait cycle; TIMEOUT_CYCLES=0 disables expiry.
module wrapper_vr_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [W-1:0] r_count;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (count_en)
            r_count <= r_count + W'(1);
    end

    assign expired = (TIMEOUT_CYCLES != 0) && count_en && (r_count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wrapper_ahb_vr_multichannel.sv
// wrapper_ahb_vr_multichannel: AHB-Lite slave fanning out to NUM_CHANNELS
// valid/ready register channels, with ERROR on illegal size and wait timeout.
module wrapper_ahb_vr_multichannel
    import wrapper_ahb_vr_pkg::*;
#(
    parameter int ADDRWIDTH      = 12,
    parameter int NUM_CHANNELS   = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int CHW           = $clog2(NUM_CHANNELS),
    localparam int LAW           = ADDRWIDTH - CHW
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      hsels,
    input  logic                      hreadys,
    input  logic                      hwrites,
    input  logic [ADDRWIDTH-1:0]      haddrs,
    input  logic [1:0]                htranss,
    input  logic [2:0]                hsizes,
    input  logic [31:0]               hwdatas,
    output logic                      hreadyouts,
    output logic                      hresps,
    output logic [31:0]               hrdatas,
    output logic [LAW-1:0]            ch_addr,
    output logic [31:0]               ch_wdata,
    output logic [NUM_CHANNELS-1:0]   ch_read_en,
    output logic [NUM_CHANNELS-1:0]   ch_write_en,
    output logic [NUM_CHANNELS*4-1:0] ch_byte_strobe,
    input  logic [NUM_CHANNELS*32-1:0] ch_rdata,
    input  logic [NUM_CHANNELS-1:0]   ch_rready,
    input  logic [NUM_CHANNELS-1:0]   ch_wready
);

    state_t                    r_state;
    logic [CHW-1:0]            r_sel;
    logic                      r_write;
    logic [LAW-1:0]            r_addr;
    logic [NUM_CHANNELS-1:0]   r_rd_en;
    logic [NUM_CHANNELS-1:0]   r_wr_en;
    logic [NUM_CHANNELS*4-1:0] r_strobe;

    logic [CHW-1:0]            w_idx;
    logic [NUM_CHANNELS-1:0]   w_onehot;
    logic [NUM_CHANNELS*4-1:0] w_strobe;
    logic                      w_accept;
    logic                      w_legal;
    logic                      w_ready;
    logic                      w_access;
    logic                      w_take;
    logic                      w_expired;

    assign w_idx    = haddrs[ADDRWIDTH-1:LAW];
    assign w_onehot = NUM_CHANNELS'(1) << w_idx;
    assign w_strobe = (NUM_CHANNELS*4)'(byte_strobe(hsizes, haddrs[1:0])) << {w_idx, 2'b00};
    assign w_accept = hsels & hreadys & (htranss == HTRANS_NONSEQ || htranss == HTRANS_SEQ);
    assign w_legal  = size_legal(hsizes, haddrs[1:0]);
    assign w_ready  = r_write ? ch_wready[r_sel] : ch_rready[r_sel];
    assign w_access = r_state == ACCESS;
    // A new address phase is only honoured once the previous data phase ends.
    assign w_take   = w_accept & (r_state == IDLE || r_state == ERR2 || (w_access && w_ready));

    wrapper_vr_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .clear    (w_accept),
        .count_en (w_access & ~w_ready),
        .expired  (w_expired)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_rd_en  <= '0;
            r_wr_en  <= '0;
            r_strobe <= '0;
        end else begin
            r_rd_en  <= '0;
            r_wr_en  <= '0;
            r_strobe <= '0;
            if (w_take && w_legal) begin
                r_state  <= ACCESS;
                r_sel    <= w_idx;
                r_addr   <= haddrs[LAW-1:0];
                r_write  <= hwrites;
                r_rd_en  <= hwrites ? '0 : w_onehot;
                r_wr_en  <= hwrites ? w_onehot : '0;
                r_strobe <= w_strobe;
            end else if (w_take) begin
                r_state <= ERR1;
            end else if (r_state == ERR1) begin
                r_state <= ERR2;
            end else if (w_access && !w_ready && !w_expired) begin
                r_rd_en  <= r_rd_en;
                r_wr_en  <= r_wr_en;
                r_strobe <= r_strobe;
            end else if (w_access && !w_ready) begin
                r_state <= ERR1;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    always_comb begin
        hreadyouts = w_access ? w_ready : r_state != ERR1;
        hrdatas    = (w_access && !r_write) ? ch_rdata[{r_sel, 5'b0} +: 32] : 32'h0;
    end

    assign hresps         = r_state == ERR1 || r_state == ERR2;
    assign ch_addr        = r_addr;
    assign ch_wdata       = hwdatas;
    assign ch_read_en     = r_rd_en;
    assign ch_write_en    = r_wr_en;
    assign ch_byte_strobe = r_strobe;

endmodule

// File: tb/tb_wrapper_ahb_vr_multichannel.sv
// tb_wrapper_ahb_vr_multichannel: scenario tasks plus randomized transfers
// checked against a byte-lane/alignment model of the bridge.
module tb_wrapper_ahb_vr_multichannel;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic         hsels, hreadys, hwrites;
    logic [11:0]  haddrs;
    logic [1:0]   htranss;
    logic [2:0]   hsizes;
    logic [31:0]  hwdatas;
    logic         hreadyouts, hresps;
    logic [31:0]  hrdatas;
    logic [9:0]   ch_addr;
    logic [31:0]  ch_wdata;
    logic [3:0]   ch_read_en, ch_write_en;
    logic [15:0]  ch_byte_strobe;
    logic [127:0] ch_rdata;
    logic [3:0]   ch_rready, ch_wready;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;
    assign hreadys = hreadyouts;

    wrapper_ahb_vr_multichannel #(.ADDRWIDTH(12), .NUM_CHANNELS(4), .TIMEOUT_CYCLES(4)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsels(hsels), .hreadys(hreadys), .hwrites(hwrites),
        .haddrs(haddrs), .htranss(htranss), .hsizes(hsizes), .hwdatas(hwdatas),
        .hreadyouts(hreadyouts), .hresps(hresps), .hrdatas(hrdatas), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_read_en(ch_read_en), .ch_write_en(ch_write_en),
        .ch_byte_strobe(ch_byte_strobe), .ch_rdata(ch_rdata), .ch_rready(ch_rready),
        .ch_wready(ch_wready)
    );

    // Model: a transfer covers bytes [a, a+2^size); legal when naturally aligned.
    function automatic logic m_legal(input int size, input int a);
        return size <= 2 && (a % (1 << size)) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input int size, input int a);
        logic [3:0] s = 4'b0;
        for (int i = 0; i < 4; i++)
            if (size <= 2 && i >= a && i < a + (1 << size)) s[i] = 1'b1;
        return s;
    endfunction

    task automatic xfer(input string tag, input logic wr, input int ch, input logic [9:0] la,
                        input int size, input int waits);
        logic [3:0]  oh;
        logic [15:0] es;
        logic        leg;
        logic [31:0] wd, erd;
        oh  = 4'b0001 << ch;
        es  = 16'(m_strb(size, int'(la[1:0]))) << (ch * 4);
        leg = m_legal(size, int'(la[1:0]));
        wd  = $urandom;
        @(negedge hclk);
        for (int c = 0; c < 4; c++) ch_rdata[c*32 +: 32] = $urandom;
        ch_rready = 4'hF;
        ch_wready = 4'hF;
        if (waits > 0) begin
            if (wr) ch_wready[ch] = 1'b0; else ch_rready[ch] = 1'b0;
        end
        erd = wr ? 32'h0 : ch_rdata[ch*32 +: 32];
        hsels = 1'b1; htranss = 2'b10; hwrites = wr;
        haddrs = {2'(ch), la}; hsizes = 3'(size);
        @(negedge hclk);
        hsels = 1'b0; htranss = 2'b00; hwdatas = wd;
        if (leg) begin
            for (int k = 0; k <= waits; k++) begin
                if (k == waits) begin
                    if (wr) ch_wready[ch] = 1'b1; else ch_rready[ch] = 1'b1;
                end
                #1;
                checks++;
                if ({ch_read_en, ch_write_en} !== {wr ? 4'h0 : oh, wr ? oh : 4'h0}) begin
                    errors++;
                    $display("FAIL %s en k=%0d got %b exp %b", tag, k, {ch_read_en, ch_write_en}, {wr ? 4'h0 : oh, wr ? oh : 4'h0});
                end
                checks++;
                if ({ch_addr, ch_byte_strobe} !== {la, es}) begin
                    errors++;
                    $display("FAIL %s addr/strobe got %h/%h exp %h/%h", tag, ch_addr, ch_byte_strobe, la, es);
                end
                checks++;
                if ({hreadyouts, hresps} !== {k == waits, 1'b0}) begin
                    errors++;
                    $display("FAIL %s ready/resp k=%0d got %b%b exp %b0", tag, k, hreadyouts, hresps, k == waits);
                end
                checks++;
                if ({hrdatas, ch_wdata} !== {erd, wd}) begin
                    errors++;
                    $display("FAIL %s rdata/wdata got %h/%h exp %h/%h", tag, hrdatas, ch_wdata, erd, wd);
                end
                @(negedge hclk);
            end
        end else begin
            #1;
            checks++;
            if ({hreadyouts, hresps, ch_read_en, ch_write_en} !== 10'b01_0000_0000) begin
                errors++;
                $display("FAIL %s err1 got %b exp 0100000000", tag, {hreadyouts, hresps, ch_read_en, ch_write_en});
            end
            @(negedge hclk);
            #1;
            checks++;
            if ({hreadyouts, hresps, ch_read_en, ch_write_en} !== 10'b11_0000_0000) begin
                errors++;
                $display("FAIL %s err2 got %b exp 1100000000", tag, {hreadyouts, hresps, ch_read_en, ch_write_en});
            end
            @(negedge hclk);
        end
        #1;
        checks++;
        if ({hreadyouts, hresps, ch_read_en, ch_write_en, ch_byte_strobe} !== {2'b10, 24'h0}) begin
            errors++;
            $display("FAIL %s idle got %b%b %b %b %h", tag, hreadyouts, hresps, ch_read_en, ch_write_en, ch_byte_strobe);
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0; hsels = 1'b0; hwrites = 1'b0; haddrs = '0; htranss = 2'b00;
        hsizes = 3'b0; hwdatas = '0; ch_rdata = '0; ch_rready = 4'hF; ch_wready = 4'hF;
        repeat (3) @(negedge hclk);
        checks++;
        if ({hreadyouts, hresps, hrdatas, ch_addr, ch_read_en, ch_write_en, ch_byte_strobe} !== {2'b10, 66'h0}) begin
            errors++;
            $display("FAIL reset got %b%b %h %h %b %b %h exp 10 0...", hreadyouts, hresps, hrdatas, ch_addr, ch_read_en, ch_write_en, ch_byte_strobe);
        end
        hresetn = 1'b1;
    endtask

    task automatic test_plan_transfers();
        xfer("wr_c08", 1'b1, 3, 10'h008, 2, 0);
        xfer("rd_403", 1'b0, 1, 10'h003, 0, 3);
        xfer("wr_002_misaligned", 1'b1, 0, 10'h002, 2, 0);
        xfer("half_hi", 1'b0, 2, 10'h0F2, 1, 1);
        xfer("size3", 1'b0, 1, 10'h000, 3, 0);
    endtask

    task automatic test_timeout();
        @(negedge hclk);
        ch_rready = 4'hF; ch_wready = 4'hB;
        hsels = 1'b1; htranss = 2'b10; hwrites = 1'b1; haddrs = 12'h810; hsizes = 3'd2;
        @(negedge hclk);
        hsels = 1'b0; htranss = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({hreadyouts, hresps, ch_write_en} !== 6'b00_0100) begin
                errors++;
                $display("FAIL timeout_wait k=%0d got %b exp 000100", k, {hreadyouts, hresps, ch_write_en});
            end
            @(negedge hclk);
        end
        #1;
        checks++;
        if ({hreadyouts, hresps, ch_write_en, ch_read_en} !== 10'b01_0000_0000) begin
            errors++;
            $display("FAIL timeout_err1 got %b exp 0100000000", {hreadyouts, hresps, ch_write_en, ch_read_en});
        end
        @(negedge hclk);
        #1;
        checks++;
        if ({hreadyouts, hresps, ch_write_en, ch_read_en} !== 10'b11_0000_0000) begin
            errors++;
            $display("FAIL timeout_err2 got %b exp 1100000000", {hreadyouts, hresps, ch_write_en, ch_read_en});
        end
        ch_wready = 4'hF;
        xfer("after_timeout_rd0", 1'b0, 0, 10'h044, 2, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        wd = $urandom;
        @(negedge hclk);
        for (int c = 0; c < 4; c++) ch_rdata[c*32 +: 32] = $urandom;
        ch_rready = 4'hF; ch_wready = 4'hF;
        hsels = 1'b1; htranss = 2'b10; hwrites = 1'b1; haddrs = 12'h010; hsizes = 3'd2;
        @(negedge hclk);
        hwdatas = wd; hwrites = 1'b0; haddrs = 12'hC20; htranss = 2'b11;
        #1;
        checks++;
        if ({ch_write_en, ch_read_en, hreadyouts, ch_wdata} !== {8'b0001_0000, 1'b1, wd}) begin
            errors++;
            $display("FAIL b2b_write got %b %b %b %h", ch_write_en, ch_read_en, hreadyouts, ch_wdata);
        end
        @(negedge hclk);
        hsels = 1'b0; htranss = 2'b00;
        #1;
        checks++;
        if ({ch_write_en, ch_read_en, ch_addr, hrdatas} !== {8'b0000_1000, 10'h020, ch_rdata[96 +: 32]}) begin
            errors++;
            $display("FAIL b2b_read got %b %b %h %h exp rd 1000 addr 020 data %h", ch_write_en, ch_read_en, ch_addr, hrdatas, ch_rdata[96 +: 32]);
        end
        @(negedge hclk);
        #1;
        checks++;
        if ({hreadyouts, ch_write_en, ch_read_en} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL b2b_idle got %b exp 100000000", {hreadyouts, ch_write_en, ch_read_en});
        end
    endtask

    task automatic test_async_reset();
        @(negedge hclk);
        ch_rdata[32 +: 32] = 32'hDEADBEEF; ch_rready = 4'hD;
        hsels = 1'b1; htranss = 2'b10; hwrites = 1'b0; haddrs = 12'h404; hsizes = 3'd2;
        @(negedge hclk);
        hsels = 1'b0; htranss = 2'b00;
        #1;
        checks++;
        if ({ch_read_en, hreadyouts, hrdatas} !== {4'b0010, 1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL arst_pre got %b %b %h", ch_read_en, hreadyouts, hrdatas);
        end
        #1 hresetn = 1'b0;
        #1;
        checks++;
        if ({hreadyouts, hresps, ch_read_en, ch_write_en, ch_byte_strobe, hrdatas} !== {2'b10, 56'h0}) begin
            errors++;
            $display("FAIL arst got %b%b %b %b %h %h", hreadyouts, hresps, ch_read_en, ch_write_en, ch_byte_strobe, hrdatas);
        end
        @(negedge hclk);
        hresetn = 1'b1; ch_rready = 4'hF;
        xfer("after_arst", 1'b1, 1, 10'h001, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            xfer("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 10'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    endtask

    initial begin
        test_reset();
        test_plan_transfers();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrapper_ahb_vr_multichannel.md
# wrapper_ahb_vr_multichannel

Parametrised AHB-Lite slave that bridges the bus to NUM_CHANNELS register-style valid/ready accelerator channels. It sits between the nanosoc AHB fabric and the accelerator engine wrapper, and generalises the two-channel input/output bridge to N channels. It adds AHB ERROR responses for illegal size/alignment and a per-transfer wait-state timeout, so a stalled engine cannot hang the bus.

## Interface
- ADDRWIDTH, 12, slave address width; top CHW = $clog2(NUM_CHANNELS) bits select the channel; LAW = ADDRWIDTH-CHW
- NUM_CHANNELS, 4, power of two, 2..8
- TIMEOUT_CYCLES, 256, max wait states before ERROR; 0 disables timeout
- hclk  in  1  clock
- hresetn  in  1  reset, asynchronous, active-low
- hsels, hreadys, hwrites  in  1  AHB select, ready-in, write
- haddrs  in  ADDRWIDTH  AHB address
- htranss  in  2  AHB transfer type
- hsizes  in  3  AHB size
- hwdatas  in  32  AHB write data
- hreadyouts  out  1  slave ready
- hresps  out  1  slave response, 1 = ERROR
- hrdatas  out  32  read data
- ch_addr  out  LAW  local address of the current data-phase transfer, shared by all channels
- ch_wdata  out  32  equal to hwdatas
- ch_read_en, ch_write_en  out  NUM_CHANNELS  one-hot per-channel enables
- ch_byte_strobe  out  NUM_CHANNELS×4  per-channel strobes
- ch_rdata  in  NUM_CHANNELS×32  per-channel read data
- ch_rready, ch_wready  in  NUM_CHANNELS  per-channel ready

## Operation
- Request accepted when hsels & hreadys & htranss[1].
- Legal request:
  - hsizes ≤ 2
  - halfword transfers have haddrs[0]=0
  - word transfers have haddrs[1:0]=0
- Accepted legal request: register channel index (haddrs[ADDRWIDTH-1:LAW]), local address, write flag and strobe, then enter ACCESS.
- Accepted illegal request: enter ERR1; no channel enable asserted.
- Strobe encoding:
  - byte: one-hot on addr[1:0]
  - halfword: 4'b0011, or 4'b1100 when addr[1]=1
  - word: 4'b1111
- FSM states IDLE, ACCESS, ERR1, ERR2:
  - IDLE: hreadyouts=1, hresps=0, all enables 0.
  - ACCESS: only the selected channel's read_en or write_en is 1, and only its strobe is driven (others 0). hreadyouts is that channel's rready (read) or wready (write). On ready=1 the transfer completes. If a new request is accepted in the same cycle, re-latch and stay in ACCESS (back-to-back pipelining); otherwise go to IDLE. Ready=0 with the timeout expired goes to ERR1.
  - ERR1: hreadyouts=0, hresps=1, enables 0. Always goes to ERR2.
  - ERR2: hreadyouts=1, hresps=1. A request accepted here is processed normally (ACCESS or ERR1); otherwise go to IDLE.
- hrdatas = ch_rdata[sel] in a read ACCESS, else 32'h0.
- Timeout counter, width $clog2(TIMEOUT_CYCLES+1):
  - cleared on each accepted request
  - increments each ACCESS cycle with ready=0
  - expiry = count == TIMEOUT_CYCLES-1 with ready still 0
  - TIMEOUT_CYCLES=0 never expires
- Simultaneous ready=1 and timeout expiry in the same cycle: completion wins.
- IDLE/BUSY htrans, or hsels=0: ignored, no state change except ACCESS completion.

## Timing
- Reset values: hreadyouts=1, hresps=0, hrdatas=0, ch_addr=0, all enables and strobes 0, state IDLE, counter 0.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronous); any pending channel access is dropped.
- Address phase to enable assertion: 1 cycle, since enables are registered.
- Zero-wait transfer: data phase of 1 cycle when the channel's ready is already 1.
- Error response: always exactly 2 cycles (ERR1 then ERR2).
- Timeout: a stalled transfer sees exactly TIMEOUT_CYCLES wait cycles in ACCESS, then 2 ERROR cycles.
- Outputs that are combinational from inputs: hreadyouts, hrdatas and ch_wdata only; everything else is registered.

## Structure
- Package wrapper_ahb_vr_pkg:
  - state enum (IDLE, ACCESS, ERR1, ERR2)
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HSIZE_BYTE/HALF/WORD constants
  - function byte_strobe(hsize, addr[1:0])
  - function size_legal(hsize, addr[1:0])
- Sub-module wrapper_vr_timeout_counter: parameter TIMEOUT_CYCLES; ports clear, count_en, expired.

## Test plan
- NUM_CHANNELS=4, ADDRWIDTH=12, word write to 0xC08 with ch_wready[3]=1 → next cycle ch_write_en=4'b1000, ch_addr=10'h008, ch_byte_strobe[3]=4'hF, hreadyouts=1.
- Byte read at 0x403, ch_rready[1] low for 3 cycles → ch_byte_strobe[1]=4'b1000, 3 wait states, then hrdatas=ch_rdata[1] with hreadyouts=1.
- Word write to 0x002 (misaligned) → ERR1 (hreadyouts=0, hresps=1), then ERR2 (1,1); all enables stay 0.
- TIMEOUT_CYCLES=4, ch_wready[2] stuck 0 → 4 wait cycles, then 2-cycle ERROR; enable drops in ERR1; following read to channel 0 completes normally.
- Back-to-back: write to ch0 then read from ch3 with both readys high → enables 0001 then 1000 in consecutive cycles, no IDLE gap.
- hresetn pulsed low while in ACCESS with ready=0 → immediately hreadyouts=1, enables 0, hrdatas=0.
